mix_columns_engine: RTL and testbench
=====================================

// Module: mix_columns_engine
// PURPOSE
//  Sequential, bidirectional AES MixColumns unit for the shared cipher datapath.
//  Accepts a 128-bit state over a valid/ready handshake and applies either the forward
//  matrix (02 03 01 01, circulant) or the inverse matrix (0E 0B 0D 09, circulant).
//  Processes COLS_PER_CYCLE columns per clock, so area and latency can be traded.
//  Sits between ShiftRows/InvShiftRows and AddRoundKey in both round pipelines.
// PARAMETERS
//  COLS_PER_CYCLE  1  columns transformed per clock; legal values 1, 2, 4
// PORTS
//  clk        in   1    clock; all state updates on rising edge
//  rst_n      in   1    reset; asynchronous assert, active-low
//  in_valid   in   1    in_data/in_mode are valid
//  in_ready   out  1    engine can accept a state this cycle
//  in_data    in   128  [0:127]; byte (r,c) = in_data[32c+8r +: 8], with bit 0 as MSB of byte 0
//  in_mode    in   1    0 = forward MixColumns, 1 = inverse MixColumns
//  out_valid  out  1    out_data holds a complete result
//  out_ready  in   1    downstream accepts out_data
//  out_data   out  128  transformed state, same byte layout as in_data
//  busy       out  1    high in BUSY or DONE
// BEHAVIOUR
//  Reset (asynchronous, rst_n=0): state=IDLE, col_cnt=0, out_valid=0, busy=0, out_data=0.
//   While rst_n=0, in_ready=0. After release, in_ready=1 from the first clock edge.
//  GF(2^8) arithmetic: xtime(b) = {b[6:0],0} ^ (b[7] ? 8'h1B : 0). All additions are XOR.
//   x9 = x8^x; xB = x8^x2^x; xD = x8^x4^x; xE = x8^x4^x2; x3 = x2^x.
//  Column transform: out(r,c) = XOR over k of M[r][k]*in(k,c).
//   M[r][k] = row0 coefficient rotated right by r.
//   Row0 coefficients: forward 02 03 01 01; inverse 0E 0B 0D 09.
//  FSM: IDLE, BUSY, DONE.
//   IDLE: in_ready=1. On in_valid, latch in_data and in_mode, set col_cnt=0, go BUSY.
//   BUSY: in_ready=0. Each cycle transform columns col_cnt .. col_cnt+COLS_PER_CYCLE-1
//    from the latched state into the result register; col_cnt += COLS_PER_CYCLE.
//    After the group that ends at column 3, go DONE.
//   DONE: out_valid=1; out_data is stable until the handshake completes.
//    On out_ready: drop out_valid next cycle and go IDLE.
//    If in_valid is also high in that same cycle, accept it and go directly to BUSY.
//  in_ready = (state==IDLE) | (state==DONE & out_ready).
//  Latency: 4/COLS_PER_CYCLE clocks from the accept edge to out_valid=1.
//   Throughput: one state per (4/COLS_PER_CYCLE + 1) clocks with out_ready held high.
//  Columns are independent. A partial result is never visible on out_data before DONE.
//  In BUSY and DONE, in_data and in_mode are ignored. A mode change never affects a job in flight.
//  out_ready is ignored outside DONE. col_cnt wraps to 0 only on a new accept.
//  Reset mid-operation: the job is discarded and out_valid=0 immediately (asynchronous).
//   No output is produced for the aborted job.
//  COLS_PER_CYCLE outside {1,2,4} is an elaboration-time error.
// TESTING
//  1 Fwd, CPC=1: column0 = db 13 53 45 (others 0) -> out column0 = 8e 4d a1 bc.
//    out_valid asserts exactly 4 clocks after the accept.
//  2 Inv, all CPC: state with columns 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6
//    -> db135345, f20a225c, 01010101, c6c6c6c6. out_valid latency is 4, 2, 1 for CPC=1, 2, 4.
//  3 Round trip: 1000 random states, fwd then inv -> original state.
//    in_mode is toggled randomly during BUSY with no effect on results.
//  4 Backpressure: hold out_ready=0 for 10 clocks in DONE.
//    out_data stays stable and in_ready=0. Assert out_ready together with in_valid:
//    the next job is accepted in the same cycle and out_valid deasserts next cycle.
//  5 Fwd: column d4 d4 d4 d5 -> d5 d5 d7 d6; column 2d 26 31 4c -> 4d 7e bd f8.
//  6 Drop rst_n during BUSY (CPC=1, col_cnt=2). out_valid=0 and busy=0 asynchronously.
//    After release, a fresh job completes correctly and no stale output appears.

Source files
------------

// File: rtl/mix_columns_engine.sv
// rtl/mix_columns_engine.sv - sequential bidirectional AES MixColumns engine
module mix_columns_engine #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
    input  logic         in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data,
    output logic         busy
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
        $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [2:0] CPC = 3'(COLS_PER_CYCLE);

    state_t       state_q, state_d;
    logic [2:0]   col_cnt_q, col_cnt_d;
    logic         mode_q, mode_d;
    logic [0:127] data_q, data_d;
    logic [0:127] out_q, out_d;
    logic         ready_en_q;
    logic         accept;
    int           base;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit coefficient as a sum of b, 2b, 4b and 8b.
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

    // Row r uses row-0 coefficients rotated right by r, so M[r][k] = c[(k - r) mod 4].
    function automatic logic [0:31] mix_col(input logic [0:31] col, input logic inv);
        logic [7:0]  a [4];
        logic [3:0]  c [4];
        logic [7:0]  acc;
        logic [0:31] res;
        if (inv) begin
            c[0] = 4'he; c[1] = 4'hb; c[2] = 4'hd; c[3] = 4'h9;
        end else begin
            c[0] = 4'h2; c[1] = 4'h3; c[2] = 4'h1; c[3] = 4'h1;
        end
        for (int r = 0; r < 4; r++) begin
            a[r] = col[8*r +: 8];
        end
        res = '0;
        for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) begin
                acc = acc ^ gmul(a[k], c[(k - r + 4) % 4]);
            end
            res[8*r +: 8] = acc;
        end
        return res;
    endfunction

    assign in_ready  = ready_en_q & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_data  = out_q;

    // Next-state: latch on accept, transform a column group per BUSY cycle, publish at the end.
    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        mode_d    = mode_q;
        data_d    = data_q;
        out_d     = out_q;
        base      = 0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    data_d    = in_data;
                    mode_d    = in_mode;
                    col_cnt_d = 3'd0;
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                    base = 32 * ((int'(col_cnt_q[1:0]) + g) % 4);
                    data_d[base +: 32] = mix_col(data_q[base +: 32], mode_q);
                end
                col_cnt_d = col_cnt_q + CPC;
                if (col_cnt_q + CPC == 3'd4) begin
                    out_d   = data_d;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    if (accept) begin
                        data_d    = in_data;
                        mode_d    = in_mode;
                        col_cnt_d = 3'd0;
                        state_d   = S_BUSY;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            col_cnt_q <= 3'd0;
            mode_q    <= 1'b0;
            data_q    <= '0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            mode_q    <= mode_d;
            data_q    <= data_d;
            out_q     <= out_d;
        end
    end

    // Holds in_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mix_columns_engine.sv
// tb/tb_mix_columns_engine.sv - directed self-checking bench for mix_columns_engine
module tb_mix_columns_engine;

    logic         clk;
    logic         rst_n;
    logic         in_valid, in_valid_x;
    logic [0:127] in_data;
    logic         in_mode;
    logic         out_ready;
    logic         in_ready, in_ready2, in_ready4;
    logic         out_valid, out_valid2, out_valid4;
    logic [0:127] out_data, out_data2, out_data4;
    logic         busy, busy2, busy4;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [0:127] V1  = 128'hdb135345_00000000_00000000_00000000;
    localparam logic [0:127] E1  = 128'h8e4da1bc_00000000_00000000_00000000;
    localparam logic [0:127] VI  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [0:127] EI  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [0:127] V5  = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
    localparam logic [0:127] E5  = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;

    mix_columns_engine #(.COLS_PER_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    mix_columns_engine #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_x), .in_ready(in_ready2),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid2),
        .out_ready(out_ready), .out_data(out_data2), .busy(busy2)
    );

    mix_columns_engine #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_x), .in_ready(in_ready4),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid4),
        .out_ready(out_ready), .out_data(out_data4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_job(input logic [0:127] d, input logic m);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        n_assert++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_ready: in_ready=%b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            in_mode = 1'($urandom);
            in_data = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            lat++;
        end
        n_assert++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL done_timeout: out_valid=%b after %0d clocks expected 1", out_valid, lat);
        end
    endtask

    task automatic finish_job();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_job(input logic [0:127] d, input logic m, output logic [0:127] res, output int lat);
        start_job(d, m);
        wait_done(lat);
        res = out_data;
        finish_job();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_assert++;
        if ({in_ready, out_valid, busy} !== 3'b000 || out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_state: rdy/vld/busy=%b data=%h expected 000 and 0",
                     {in_ready, out_valid, busy}, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_assert++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: in_ready=%b expected 0", in_ready);
        end
        @(posedge clk);
        #1;
        n_assert++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_edge: in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic test_fwd_cpc1();
        logic [0:127] res;
        int           lat;
        run_job(V1, 1'b0, res, lat);
        n_assert++;
        if (res !== E1) begin
            n_fail++;
            $display("FAIL fwd_col0: got %h expected %h", res, E1);
        end
        n_assert++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL fwd_latency: got %0d expected 4", lat);
        end
    endtask

    task automatic test_fwd_vectors();
        logic [0:127] res;
        int           lat;
        run_job(V5, 1'b0, res, lat);
        n_assert++;
        if (res !== E5) begin
            n_fail++;
            $display("FAIL fwd_vectors: got %h expected %h", res, E5);
        end
    endtask

    task automatic test_inv_all_cpc();
        int lat1, lat2, lat4;
        logic [0:127] r1, r2, r4;
        lat1 = 0; lat2 = 0; lat4 = 0;
        r1 = '0; r2 = '0; r4 = '0;
        @(negedge clk);
        in_valid   = 1'b1;
        in_valid_x = 1'b1;
        in_data    = VI;
        in_mode    = 1'b1;
        n_assert++;
        if ({in_ready, in_ready2, in_ready4} !== 3'b111) begin
            n_fail++;
            $display("FAIL inv_ready: got %b expected 111", {in_ready, in_ready2, in_ready4});
        end
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_valid_x = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            in_mode = 1'($urandom);
            @(posedge clk);
            #1;
            if (out_valid  === 1'b1 && lat1 == 0) begin lat1 = cyc; r1 = out_data;  end
            if (out_valid2 === 1'b1 && lat2 == 0) begin lat2 = cyc; r2 = out_data2; end
            if (out_valid4 === 1'b1 && lat4 == 0) begin lat4 = cyc; r4 = out_data4; end
        end
        n_assert++;
        if (lat1 != 4 || lat2 != 2 || lat4 != 1) begin
            n_fail++;
            $display("FAIL inv_latency: got %0d/%0d/%0d expected 4/2/1", lat1, lat2, lat4);
        end
        n_assert++;
        if (r1 !== EI) begin
            n_fail++;
            $display("FAIL inv_cpc1: got %h expected %h", r1, EI);
        end
        n_assert++;
        if (r2 !== EI) begin
            n_fail++;
            $display("FAIL inv_cpc2: got %h expected %h", r2, EI);
        end
        n_assert++;
        if (r4 !== EI) begin
            n_fail++;
            $display("FAIL inv_cpc4: got %h expected %h", r4, EI);
        end
        finish_job();
    endtask

    task automatic test_round_trip();
        logic [0:127] orig, r1, r2;
        int           lat;
        int           bad;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            orig = {$urandom, $urandom, $urandom, $urandom};
            run_job(orig, 1'b0, r1, lat);
            run_job(r1, 1'b1, r2, lat);
            n_assert++;
            if (r2 !== orig) begin
                n_fail++;
                bad++;
                if (bad <= 5)
                    $display("FAIL round_trip[%0d]: got %h expected %h", i, r2, orig);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        bad = 0;
        start_job(V5, 1'b0);
        wait_done(lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_data !== E5 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        n_assert++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_stable: %0d bad cycles data=%h rdy=%b expected 0 bad", bad, out_data, in_ready);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = E5;
        in_mode   = 1'b1;
        #1;
        n_assert++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL done_ready: in_ready=%b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_assert++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL chained_accept: vld/busy=%b%b expected 01", out_valid, busy);
        end
        wait_done(lat);
        n_assert++;
        if (out_data !== V5 || lat !== 4) begin
            n_fail++;
            $display("FAIL chained_result: got %h lat %0d expected %h lat 4", out_data, lat, V5);
        end
        finish_job();
    endtask

    task automatic test_reset_midjob();
        logic [0:127] res;
        int           lat;
        int           stale;
        stale = 0;
        start_job(V5, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        n_assert++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midjob_busy: busy/vld=%b%b expected 10", busy, out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_assert++;
        if ({out_valid, busy, in_ready} !== 3'b000 || out_data !== '0) begin
            n_fail++;
            $display("FAIL async_abort: vld/busy/rdy=%b data=%h expected 000 and 0",
                     {out_valid, busy, in_ready}, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) stale++;
        end
        n_assert++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL stale_output: %0d cycles with output activity expected 0", stale);
        end
        run_job(V1, 1'b0, res, lat);
        n_assert++;
        if (res !== E1 || lat !== 4) begin
            n_fail++;
            $display("FAIL fresh_job: got %h lat %0d expected %h lat 4", res, lat, E1);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_valid_x = 1'b0;
        in_data    = '0;
        in_mode    = 1'b0;
        out_ready  = 1'b0;
        test_reset();
        test_fwd_cpc1();
        test_inv_all_cpc();
        test_fwd_vectors();
        test_backpressure();
        test_round_trip();
        test_reset_midjob();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
